// File: rtl/iob_ibus_dbus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus arbiter: state encoding,
// master indices, priority modes and the winner-selection rule.
package iob_ibus_dbus_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic IBUS = 1'b0;
    localparam logic DBUS = 1'b1;

    localparam int unsigned PRIO_RR   = 0;
    localparam int unsigned PRIO_DBUS = 1;

    // Round-robin hands a tie to the master that was not granted last.
    function automatic logic pick_winner(input int unsigned prio,
                                         input logic [1:0]  cand,
                                         input logic        last);
        if (prio == PRIO_DBUS) return cand[DBUS] ? DBUS : IBUS;
        if (prio == PRIO_RR && (&cand)) return ~last;
        return cand[DBUS] ? DBUS : IBUS;
    endfunction

endpackage

// File: rtl/iob_ibus_dbus_arbiter_pend_buf.sv
// One-entry request holding register for a master whose request could not
// be issued immediately; a load (set) overrides a simultaneous clear.
module iob_arb_pend_buf #(
    parameter int unsigned W = 68
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         v_o,
    output logic [W-1:0] q_o
);

    logic         v_q, v_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (set_i) begin
            v_d    = 1'b1;
            data_d = d_i;
        end else if (clr_i) begin
            v_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_o = v_q;
    assign q_o = data_q;

endmodule

// File: rtl/iob_ibus_dbus_arbiter.sv
// Merges the instruction and data IOb buses onto one slave port, buffering
// blocked requests per master and routing ready back to the owner.
module iob_ibus_dbus_arbiter
    import iob_ibus_dbus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PRIO   = 0,
    localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int unsigned RESP_W = DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  i_req,
    output logic [RESP_W-1:0] i_resp,
    input  logic [REQ_W-1:0]  d_req,
    output logic [RESP_W-1:0] d_resp,
    output logic [REQ_W-1:0]  s_req,
    input  logic [RESP_W-1:0] s_resp
);

    localparam int unsigned PAY_W = REQ_W - 1;

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;

    logic [1:0]       live_v;
    logic [PAY_W-1:0] live_pay [2];
    logic [1:0]       pend_v;
    logic [PAY_W-1:0] pend_pay [2];
    logic [1:0]       pend_set, pend_clr;
    logic [1:0]       cand;
    logic [PAY_W-1:0] cand_pay [2];

    logic              s_ready;
    logic [DATA_W-1:0] s_rdata;
    logic              win, issue, winner, busy;

    assign live_v[IBUS]   = i_req[REQ_W-1];
    assign live_v[DBUS]   = d_req[REQ_W-1];
    assign live_pay[IBUS] = i_req[PAY_W-1:0];
    assign live_pay[DBUS] = d_req[PAY_W-1:0];

    assign s_ready = s_resp[0];
    assign s_rdata = s_resp[RESP_W-1:1];

    iob_arb_pend_buf #(.W(PAY_W)) u_pend_i (
        .clk   (clk),
        .rst   (rst),
        .set_i (pend_set[IBUS]),
        .clr_i (pend_clr[IBUS]),
        .d_i   (live_pay[IBUS]),
        .v_o   (pend_v[IBUS]),
        .q_o   (pend_pay[IBUS])
    );

    iob_arb_pend_buf #(.W(PAY_W)) u_pend_d (
        .clk   (clk),
        .rst   (rst),
        .set_i (pend_set[DBUS]),
        .clr_i (pend_clr[DBUS]),
        .d_i   (live_pay[DBUS]),
        .v_o   (pend_v[DBUS]),
        .q_o   (pend_pay[DBUS])
    );

    always_comb begin
        cand           = pend_v | live_v;
        cand_pay[IBUS] = pend_v[IBUS] ? pend_pay[IBUS] : live_pay[IBUS];
        cand_pay[DBUS] = pend_v[DBUS] ? pend_pay[DBUS] : live_pay[DBUS];

        busy   = (state_q == ST_BUSY);
        win    = !busy || s_ready;
        issue  = win && (|cand);
        winner = pick_winner(PRIO, cand, last_q);

        s_req   = '0;
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;

        if (win) state_d = issue ? ST_BUSY : ST_IDLE;
        if (issue) begin
            s_req   = {1'b1, cand_pay[winner]};
            owner_d = winner;
            last_d  = winner;
        end

        // A live request is consumed only when it was itself the issued payload.
        pend_clr[IBUS] = issue && (winner == IBUS);
        pend_clr[DBUS] = issue && (winner == DBUS);
        pend_set[IBUS] = live_v[IBUS] && !(pend_clr[IBUS] && !pend_v[IBUS]);
        pend_set[DBUS] = live_v[DBUS] && !(pend_clr[DBUS] && !pend_v[DBUS]);

        i_resp = {s_rdata, s_ready && busy && (owner_q == IBUS)};
        d_resp = {s_rdata, s_ready && busy && (owner_q == DBUS)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= IBUS;
            last_q  <= DBUS;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    a_no_req_while_pending_i: assert property (@(posedge clk) disable iff (rst)
        !(live_v[IBUS] && pend_v[IBUS]));
    a_no_req_while_pending_d: assert property (@(posedge clk) disable iff (rst)
        !(live_v[DBUS] && pend_v[DBUS]));

endmodule
